// File: rtl/qlearn_pkg.sv
// qlearn_pkg
// Shared definitions for the gridworld step engine:
//   - action_e     : 2-bit action encoding (up/down/right/left)
//   - REWARD_*     : signed 8-bit step rewards
//   - out_state_e  : state of the one-entry output register (EMPTY/FULL)
package qlearn_pkg;

    typedef enum logic [1:0] {
        ACT_UP    = 2'b00,
        ACT_DOWN  = 2'b01,
        ACT_RIGHT = 2'b10,
        ACT_LEFT  = 2'b11
    } action_e;

    localparam logic signed [7:0] REWARD_GOAL = 8'sd10;
    localparam logic signed [7:0] REWARD_STEP = -8'sd1;
    localparam logic signed [7:0] REWARD_BUMP = -8'sd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/gridworld_step_if.sv
// gridworld_step_if
// Bundles the request/result handshake of the gridworld step engine.
//   master : agent side, drives st/at/valid_in and ready_in, receives results
//   slave  : engine side, receives requests, drives results and ready_out
interface gridworld_step_if #(
    parameter int SW = 5
);
    logic [SW-1:0]      st;
    logic [1:0]         at;
    logic               valid_in;
    logic               ready_out;
    logic [SW-1:0]      next_state;
    logic signed [7:0]  reward;
    logic               moved;
    logic               done;
    logic               err;
    logic               valid_out;
    logic               ready_in;
    logic [15:0]        step_cnt;

    modport master (
        output st, at, valid_in, ready_in,
        input  ready_out, next_state, reward, moved, done, err, valid_out, step_cnt
    );

    modport slave (
        input  st, at, valid_in, ready_in,
        output ready_out, next_state, reward, moved, done, err, valid_out, step_cnt
    );
endinterface

// File: rtl/grid_move.sv
// grid_move
// Purely combinational move/boundary evaluation for one gridworld step.
// Optional feature macro: OBSTACLE_EN (cells flagged in OBST_MASK block moves).
// Ports:
//   st    in  current state index
//   at    in  action (action_e encoding)
//   nxt   out resulting state (st itself when the move is illegal or st is invalid)
//   moved out 1 when nxt differs from st
//   err   out 1 when st is outside the grid
module grid_move
    import qlearn_pkg::*;
#(
    parameter int GRID_W = 5,
    parameter int GRID_H = 5,
    parameter int SW     = $clog2(GRID_W * GRID_H)
`ifdef OBSTACLE_EN
    ,
    parameter logic [GRID_W*GRID_H-1:0] OBST_MASK = '0
`endif
) (
    input  logic [SW-1:0] st,
    input  logic [1:0]    at,
    output logic [SW-1:0] nxt,
    output logic          moved,
    output logic          err
);

    localparam int CELLS = GRID_W * GRID_H;

    logic [SW-1:0] row;
    logic [SW-1:0] col;
    logic [SW-1:0] target;
    logic          in_range;
    logic          legal;

    always_comb begin
        row      = st / SW'(GRID_W);
        col      = st % SW'(GRID_W);
        // One extra bit so a full power-of-two grid does not wrap to 0.
        in_range = ({1'b0, st} < (SW + 1)'(CELLS));
        target   = st;
        legal    = 1'b0;

        unique case (action_e'(at))
            ACT_UP: begin
                if (row != '0) begin
                    target = st - SW'(GRID_W);
                    legal  = 1'b1;
                end
            end
            ACT_DOWN: begin
                if (row < SW'(GRID_H - 1)) begin
                    target = st + SW'(GRID_W);
                    legal  = 1'b1;
                end
            end
            ACT_RIGHT: begin
                if (col < SW'(GRID_W - 1)) begin
                    target = st + SW'(1);
                    legal  = 1'b1;
                end
            end
            ACT_LEFT: begin
                if (col != '0) begin
                    target = st - SW'(1);
                    legal  = 1'b1;
                end
            end
            default: ;
        endcase

`ifdef OBSTACLE_EN
        // A blocked target cell behaves exactly like a wall bump.
        if (legal && in_range && OBST_MASK[target]) begin
            legal = 1'b0;
        end
`endif

        // Illegal moves stay put at st (never fall back to state 0).
        nxt   = (in_range && legal) ? target : st;
        moved = in_range && legal;
        err   = !in_range;
    end

endmodule

// File: rtl/gridworld_step.sv
// gridworld_step
// One-step gridworld environment with a single-entry registered output stage.
// Optional feature macro: OBSTACLE_EN (enables OBST_MASK blocked cells).
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   st, at, valid_in      request (state, action), accepted when ready_out
//   ready_out             !valid_out || ready_in, held low during reset
//   next_state, reward    registered step result
//   moved, done, err      registered result flags
//   valid_out, ready_in   result handshake
//   step_cnt              steps taken in the current episode
module gridworld_step
    import qlearn_pkg::*;
#(
    parameter int GRID_W     = 5,
    parameter int GRID_H     = 5,
    parameter int GOAL_STATE = 24,
    parameter int MAX_STEPS  = 64,
    parameter logic [GRID_W*GRID_H-1:0] OBST_MASK = '0,
    localparam int SW        = $clog2(GRID_W * GRID_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     st,
    input  logic [1:0]        at,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [SW-1:0]     next_state,
    output logic signed [7:0] reward,
    output logic              moved,
    output logic              done,
    output logic              err,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [15:0]       step_cnt
);

    out_state_e        state_q, state_d;
    logic [SW-1:0]     next_state_q, next_state_d;
    logic signed [7:0] reward_q, reward_d;
    logic              moved_q, moved_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       step_cnt_q, step_cnt_d;

    logic [SW-1:0]     mv_nxt;
    logic              mv_moved;
    logic              mv_err;
    logic              accept;
    logic              at_goal;
    logic [15:0]       cnt_inc;

    grid_move #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .SW        (SW)
`ifdef OBSTACLE_EN
        ,
        .OBST_MASK (OBST_MASK)
`endif
    ) u_move (
        .st    (st),
        .at    (at),
        .nxt   (mv_nxt),
        .moved (mv_moved),
        .err   (mv_err)
    );

    assign valid_out = (state_q == ST_FULL);
    assign ready_out = !rst && (!valid_out || ready_in);
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d      = state_q;
        next_state_d = next_state_q;
        reward_d     = reward_q;
        moved_d      = moved_q;
        done_d       = done_q;
        err_d        = err_q;
        step_cnt_d   = step_cnt_q;
        cnt_inc      = step_cnt_q + 16'd1;
        at_goal      = (mv_nxt == SW'(GOAL_STATE));

        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            // Accept while draining keeps the slot full: one result per cycle.
            ST_FULL:  if (ready_in && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (accept) begin
            next_state_d = mv_nxt;
            moved_d      = mv_moved;
            err_d        = mv_err;
            if (mv_err) begin
                // Invalid state: penalise, but leave the episode untouched.
                reward_d = REWARD_BUMP;
                done_d   = 1'b0;
            end else begin
                if (at_goal) begin
                    reward_d = REWARD_GOAL;
                end else if (!mv_moved) begin
                    reward_d = REWARD_BUMP;
                end else begin
                    reward_d = REWARD_STEP;
                end
                done_d     = at_goal || (cnt_inc == 16'(MAX_STEPS));
                // Episode end restarts the count so the next step is step 1.
                step_cnt_d = done_d ? 16'd0 : cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            next_state_q <= '0;
            reward_q     <= '0;
            moved_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            next_state_q <= next_state_d;
            reward_q     <= reward_d;
            moved_q      <= moved_d;
            done_q       <= done_d;
            err_q        <= err_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign next_state = next_state_q;
    assign reward     = reward_q;
    assign moved      = moved_q;
    assign done       = done_q;
    assign err        = err_q;
    assign step_cnt   = step_cnt_q;

endmodule
